mips_dmem_mmio: RTL and testbench
=================================

// Module: mips_dmem_mmio
// PURPOSE
//  Responder for the single-cycle MIPS data-memory port (memwrite/memaddr/memwritedata/memreaddata).
//  Word RAM below MMIO_BASE; memory-mapped regs at MMIO_BASE: TX byte FIFO streaming out on a valid/ready
//  port, plus free-running timer with compare interrupt. Sits beside the CPU in the top level, replacing plain dmem.
// PARAMETERS
//  RAM_WORDS   64             RAM depth in 32-bit words; power of 2, >=2
//  FIFO_DEPTH  4              TX FIFO entries; power of 2, 2..128
//  MMIO_BASE   32'hFFFF0000   base of register window; regs at +0x0,+0x4,+0x8,+0xC
// PORTS
//  clk           in   1   clock; all state updates on rising edge
//  reset         in   1   synchronous, active-high reset
//  memwrite      in   1   CPU store strobe, sampled at rising edge
//  memaddr       in   32  CPU byte address (ALU result)
//  memwritedata  in   32  CPU store data
//  memreaddata   out  32  load data, combinational from memaddr and current state
//  tx_valid      out  1   FIFO head valid
//  tx_data       out  8   FIFO head byte
//  tx_ready      in   1   sink accepts head when tx_valid & tx_ready
//  irq           out  1   registered copy of STATUS.irq_pend
// BEHAVIOUR
//  Decode: memaddr >= MMIO_BASE -> MMIO (offset memaddr[3:2]; memaddr[15:4]!=0 -> unmapped); else RAM,
//   index memaddr[log2(RAM_WORDS)+1:2], higher bits and [1:0] ignored (aliasing is intentional).
//  Reads: zero-latency combinational (CPU has no stall). Writes: commit at rising edge when memwrite=1.
//  RAM: not reset, no init. Write-then-read same word next cycle returns new data.
//  Reg map: +0x0 TXDATA  W: push memwritedata[7:0]; R: 0
//           +0x4 STATUS  R: [0]irq_pend [1]tx_ovf [2]empty [3]full [15:8]count, rest 0
//                        W: bit0=1 clears irq_pend, bit1=1 clears tx_ovf (write-1-to-clear)
//           +0x8 TIMER   R: count; W: load count (load beats increment that cycle)
//           +0xC TIMECMP R/W compare value
//  Unmapped MMIO: read 0, write ignored.
//  FIFO: push on TXDATA write; pop on tx_valid & tx_ready. No bypass: push into empty -> tx_valid next cycle.
//   Full & push & pop same cycle: both happen, count unchanged. Full & push, no pop: byte dropped,
//   tx_ovf<=1. Pointers wrap modulo FIFO_DEPTH. tx_data holds head; don't-care when !tx_valid.
//  Timer: count+1 every cycle, wraps 0xFFFFFFFF->0. count==cmp in cycle N -> irq_pend=1 at N+1.
//   Same-cycle set and W1C clear: set wins. irq follows irq_pend, one cycle later.
//  Reset: FIFO empty (tx_valid=0, count=0), tx_ovf=0, count=0, cmp=32'hFFFFFFFF, irq_pend=0, irq=0.
//   Reset during activity discards queued bytes; a concurrent memwrite is ignored.
// CONFIGURATION
//  MMIO_TIMER_EN defined: timer, TIMECMP, irq_pend and irq as above.
//  Not defined: no timer logic; TIMER/TIMECMP read 0, writes ignored; STATUS[0]=0; irq tied 0.
// TESTING
//  1 RAM: sw 0xDEADBEEF @0x10, lw @0x10 next cycle -> 0xDEADBEEF; lw @0x110 (RAM_WORDS=64) -> aliases same word.
//  2 TX: tx_ready=0, push 0x41,0x42 -> tx_valid=1, tx_data=0x41, STATUS[15:8]=2; raise tx_ready -> 0x41 then 0x42, then empty=1.
//  3 Overflow: tx_ready=0, push 5 bytes (DEPTH=4) -> full=1, tx_ovf=1, 5th byte lost; W1C 0x2 -> tx_ovf=0.
//  4 Full+push+pop same cycle -> count stays 4; output order preserved with new byte last.
//  5 Timer (EN): write TIMER=0, TIMECMP=10 -> irq_pend set 11 cycles after load, irq one cycle later; W1C 0x1 clears both.
//  6 Reset mid-stream with 3 queued bytes -> tx_valid=0 next cycle; STATUS reads 0x00000004; without EN, TIMER reads 0.

Source files
------------

// File: rtl/mips_dmem_mmio.sv
// Data-memory responder for the single-cycle MIPS core: word RAM plus an MMIO window
// holding a TX byte FIFO and (when MMIO_TIMER_EN is defined) a compare-interrupt timer.
module mips_dmem_mmio #(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic [31:0] memreaddata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        irq
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_count;
    logic          tx_ovf;
    logic          irq_pend;
    logic [31:0]   tmr_count, tmr_cmp;

    logic          is_mmio, mapped, wr_reg;
    logic [1:0]    reg_sel;
    logic          wr_ram, wr_status;
    logic          fifo_empty, fifo_full, push_req, push_ok, pop;
    logic [7:0]    count8;
    logic [31:0]   status_word;

    assign is_mmio   = memaddr >= MMIO_BASE;
    assign mapped    = memaddr[15:4] == 12'd0;
    assign reg_sel   = memaddr[3:2];
    assign wr_ram    = memwrite & ~reset & ~is_mmio;
    assign wr_reg    = memwrite & is_mmio & mapped;
    assign wr_status = wr_reg & (reg_sel == 2'd1);

    assign fifo_empty = fifo_count == '0;
    assign fifo_full  = fifo_count == CW'(FIFO_DEPTH);
    assign push_req   = wr_reg & (reg_sel == 2'd0);
    assign pop        = tx_valid & tx_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok    = push_req & (~fifo_full | pop);

    assign tx_valid = ~fifo_empty;
    assign tx_data  = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ram)
            ram[memaddr[AW+1:2]] <= memwritedata;
    end

    always_ff @(posedge clk) begin
        if (push_ok && !reset)
            fifo_mem[wr_ptr] <= memwritedata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            tx_ovf     <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (push_req && !push_ok)
                tx_ovf <= 1'b1;
            else if (wr_status && memwritedata[1])
                tx_ovf <= 1'b0;
        end
    end

`ifdef MMIO_TIMER_EN
    logic wr_timer, wr_timecmp, irq_q;

    assign wr_timer   = wr_reg & (reg_sel == 2'd2);
    assign wr_timecmp = wr_reg & (reg_sel == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_count <= '0;
            tmr_cmp   <= 32'hFFFFFFFF;
            irq_pend  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            tmr_count <= wr_timer ? memwritedata : tmr_count + 32'd1;
            if (wr_timecmp)
                tmr_cmp <= memwritedata;
            // A match in the same cycle as a W1C clear keeps the interrupt pending.
            if (tmr_count == tmr_cmp)
                irq_pend <= 1'b1;
            else if (wr_status && memwritedata[0])
                irq_pend <= 1'b0;
            irq_q <= irq_pend;
        end
    end

    assign irq = irq_q;
`else
    logic unused_wdata;

    assign tmr_count    = '0;
    assign tmr_cmp      = '0;
    assign irq_pend     = 1'b0;
    assign irq          = 1'b0;
    assign unused_wdata = ^memwritedata[31:8];
`endif

    assign count8      = 8'(fifo_count);
    assign status_word = {16'd0, count8, 4'd0, fifo_full, fifo_empty, tx_ovf, irq_pend};

    always_comb begin
        memreaddata = '0;
        if (!is_mmio) begin
            memreaddata = ram[memaddr[AW+1:2]];
        end else if (mapped) begin
            case (reg_sel)
                2'd1:    memreaddata = status_word;
                2'd2:    memreaddata = tmr_count;
                2'd3:    memreaddata = tmr_cmp;
                default: memreaddata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_dmem_mmio.sv
// Directed bench for mips_dmem_mmio: vector table for RAM/TX basics, hand sequences
// for overflow, full push+pop, timer interrupt (MMIO_TIMER_EN) and mid-stream reset.
module tb_mips_dmem_mmio;
    localparam logic [31:0] A_TX   = 32'hFFFF0000;
    localparam logic [31:0] A_ST   = 32'hFFFF0004;
    localparam logic [31:0] A_TMR  = 32'hFFFF0008;
    localparam logic [31:0] A_CMP  = 32'hFFFF000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] memaddr = '0;
    logic [31:0] memwritedata = '0;
    logic [31:0] memreaddata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        irq;

    int checks = 0;
    int errors = 0;

    mips_dmem_mmio dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .memaddr(memaddr),
        .memwritedata(memwritedata), .memreaddata(memreaddata),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rdy;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_valid;
        logic [7:0]  exp_txd;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1;
        memaddr = a;
        memwritedata = d;
        step();
        memwrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        memaddr = a;
        #1;
        d = memreaddata;
    endtask

    task automatic do_reset();
        memwrite = 1'b0;
        tx_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    logic [31:0] r;
    logic [7:0]  exp_bytes[4];

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0, 8'h00};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 32'h0000_0110, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 32'h0000_0014, 32'h12345678, 1'b0, 1'b0, 32'h0,        1'b0, 8'h00};
        vecs[4]  = '{1'b0, 32'h0000_0017, 32'h0,        1'b0, 1'b1, 32'h12345678, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, A_ST,          32'h0,        1'b0, 1'b1, 32'h00000004, 1'b0, 8'h00};
        vecs[6]  = '{1'b1, A_TX,          32'h00000041, 1'b0, 1'b1, 32'h0,        1'b0, 8'h00};
        vecs[7]  = '{1'b1, A_TX,          32'h00000142, 1'b0, 1'b1, 32'h0,        1'b1, 8'h41};
        vecs[8]  = '{1'b0, A_ST,          32'h0,        1'b0, 1'b1, 32'h00000200, 1'b1, 8'h41};
        vecs[9]  = '{1'b1, 32'hFFFF0010,  32'hFFFFFFFF, 1'b0, 1'b1, 32'h0,        1'b1, 8'h41};
        vecs[10] = '{1'b0, A_ST,          32'h0,        1'b1, 1'b1, 32'h00000200, 1'b1, 8'h41};
        vecs[11] = '{1'b0, A_ST,          32'h0,        1'b1, 1'b1, 32'h00000100, 1'b1, 8'h42};
        vecs[12] = '{1'b0, A_ST,          32'h0,        1'b0, 1'b1, 32'h00000004, 1'b0, 8'h00};
        vecs[13] = '{1'b0, 32'h0000_0010, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 8'h00};
        vecs[14] = '{1'b0, 32'h8000_0010, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 8'h00};
        vecs[15] = '{1'b1, A_TX,          32'h00000055, 1'b1, 1'b0, 32'h0,        1'b0, 8'h00};
        vecs[16] = '{1'b0, A_ST,          32'h0,        1'b1, 1'b1, 32'h00000100, 1'b1, 8'h55};
        vecs[17] = '{1'b0, A_ST,          32'h0,        1'b0, 1'b1, 32'h00000004, 1'b0, 8'h00};

        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rd(A_ST, r);
        chk("rst_status", r, 32'h00000004);
`ifdef MMIO_TIMER_EN
        rd(A_CMP, r);
        chk("rst_timecmp", r, 32'hFFFFFFFF);
`else
        rd(A_CMP, r);
        chk("rst_timecmp_off", r, 32'h0);
`endif
        step();

        // Vector table: one record per cycle, outputs checked before the edge commits it
        for (int i = 0; i < 18; i++) begin
            memwrite = vecs[i].we;
            memaddr = vecs[i].addr;
            memwritedata = vecs[i].wd;
            tx_ready = vecs[i].rdy;
            #2;
            if (vecs[i].chk_rd)
                chk($sformatf("vec%0d_rd", i), memreaddata, vecs[i].exp_rd);
            chk($sformatf("vec%0d_valid", i), {31'd0, tx_valid}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid)
                chk($sformatf("vec%0d_txdata", i), {24'd0, tx_data}, {24'd0, vecs[i].exp_txd});
            step();
        end
        memwrite = 1'b0;
        tx_ready = 1'b0;

        // Overflow: five pushes into a depth-4 FIFO
        do_reset();
        for (int i = 1; i <= 5; i++)
            wr(A_TX, 32'(i));
        rd(A_ST, r);
        chk("ovf_status", r, 32'h0000040A);
        wr(A_ST, 32'h2);
        rd(A_ST, r);
        chk("ovf_w1c", r, 32'h00000408);
        tx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovf_drain%0d", i), {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'(i)});
            step();
        end
        chk("ovf_lost5th", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        // Full FIFO with push and pop in the same cycle
        do_reset();
        for (int i = 0; i < 4; i++)
            wr(A_TX, 32'h11 + 32'(i));
        memwrite = 1'b1;
        memaddr = A_TX;
        memwritedata = 32'h15;
        tx_ready = 1'b1;
        #1;
        chk("fpp_head", {24'd0, tx_data}, 32'h11);
        step();
        memwrite = 1'b0;
        tx_ready = 1'b0;
        rd(A_ST, r);
        chk("fpp_status", r, 32'h00000408);
        exp_bytes[0] = 8'h12;
        exp_bytes[1] = 8'h13;
        exp_bytes[2] = 8'h14;
        exp_bytes[3] = 8'h15;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fpp_drain%0d", i), {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, exp_bytes[i]});
            step();
        end
        chk("fpp_empty", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        // Timer and compare interrupt
        do_reset();
`ifdef MMIO_TIMER_EN
        wr(A_TMR, 32'd0);
        rd(A_TMR, r);
        chk("tmr_load", r, 32'd0);
        wr(A_CMP, 32'd10);
        rd(A_TMR, r);
        chk("tmr_count1", r, 32'd1);
        repeat (9) step();
        rd(A_ST, r);
        chk("tmr_pend_before", {31'd0, r[0]}, 32'd0);
        step();
        rd(A_ST, r);
        chk("tmr_pend_set", {31'd0, r[0]}, 32'd1);
        chk("tmr_irq_lag", {31'd0, irq}, 32'd0);
        step();
        chk("tmr_irq_set", {31'd0, irq}, 32'd1);
        wr(A_ST, 32'h1);
        rd(A_ST, r);
        chk("tmr_w1c_pend", {31'd0, r[0]}, 32'd0);
        step();
        chk("tmr_irq_clr", {31'd0, irq}, 32'd0);
        rd(A_TMR, r);
        wr(A_CMP, r + 32'd2);
        step();
        wr(A_ST, 32'h1);
        rd(A_ST, r);
        chk("tmr_set_wins", {31'd0, r[0]}, 32'd1);
`else
        wr(A_TMR, 32'd5);
        wr(A_CMP, 32'd7);
        rd(A_TMR, r);
        chk("notmr_timer", r, 32'd0);
        rd(A_CMP, r);
        chk("notmr_cmp", r, 32'd0);
        repeat (10) step();
        chk("notmr_irq", {31'd0, irq}, 32'd0);
        rd(A_ST, r);
        chk("notmr_status", r, 32'h00000004);
`endif

        // Reset mid-stream with a concurrent push
        do_reset();
        for (int i = 0; i < 3; i++)
            wr(A_TX, 32'h60 + 32'(i));
        chk("rstmid_valid_before", {31'd0, tx_valid}, 32'd1);
        reset = 1'b1;
        memwrite = 1'b1;
        memaddr = A_TX;
        memwritedata = 32'h77;
        step();
        reset = 1'b0;
        memwrite = 1'b0;
        chk("rstmid_valid", {31'd0, tx_valid}, 32'd0);
        rd(A_ST, r);
        chk("rstmid_status", r, 32'h00000004);
`ifndef MMIO_TIMER_EN
        rd(A_TMR, r);
        chk("rstmid_timer", r, 32'd0);
`endif
        step();
        chk("rstmid_stay_empty", {31'd0, tx_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
